// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract: loads A then B MSD first, computes LSD first, pulses done.
// Define BCD_ADDSUB_SUB_EN to build the subtract path (operand swap, borrow chain, neg).
module bcd_addsub_serial #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [3:0]            sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    input  logic                  op_i,
    output logic [4*DIGITS-1:0]   w1_o,
    output logic [4*DIGITS-1:0]   w2_o,
    output logic [4*DIGITS+3:0]   sum_o,
    output logic                  neg_o,
    output logic                  digit_err_o,
    output logic                  done_o
);
    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {StLoadA, StLoadB, StCalc, StDone} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic         carry_q, neg_q, err_q, done_q, op_q;
    logic [W-1:0] w1_q, w2_q;
    logic [W+3:0] sum_q;

    logic         accept, last_digit, in_bad;
    logic [3:0]   in_digit, load_idx;
    logic         sub_mode, swap;
    logic [W-1:0] opa, opb;
    logic [3:0]   a_dig, b_dig, res_dig;
    logic         res_carry;
    logic [4:0]   t;

    assign sample_ready_o = (state_q == StLoadA) || (state_q == StLoadB);
    assign accept         = sample_ready_o && sample_valid_i;
    assign last_digit     = (cnt_q == 4'(DIGITS - 1));
    assign in_bad         = (sample_i > 4'd9);
    assign in_digit       = in_bad ? 4'd9 : sample_i;
    assign load_idx       = 4'(DIGITS - 1) - cnt_q;

`ifdef BCD_ADDSUB_SUB_EN
    assign sub_mode = op_q;
    // Binary compare of packed BCD orders the same as the decimal values.
    assign swap     = op_q && (w1_q < w2_q);
`else
    logic unused_op;
    assign unused_op = op_q;
    assign sub_mode  = 1'b0;
    assign swap      = 1'b0;
`endif

    always_comb begin
        opa       = swap ? w2_q : w1_q;
        opb       = swap ? w1_q : w2_q;
        a_dig     = opa[4*cnt_q +: 4];
        b_dig     = opb[4*cnt_q +: 4];
        t         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
        res_dig   = t[3:0];
        res_carry = 1'b0;
        if (t > 5'd9) begin
            res_dig   = 4'(t - 5'd10);
            res_carry = 1'b1;
        end
`ifdef BCD_ADDSUB_SUB_EN
        if (sub_mode) begin
            t         = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0, carry_q};
            res_dig   = t[3:0];
            res_carry = 1'b0;
            if (({1'b0, b_dig} + {4'b0, carry_q}) > {1'b0, a_dig}) begin
                res_dig   = 4'(t + 5'd10);
                res_carry = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StLoadA;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= 1'b0;
            w1_q    <= '0;
            w2_q    <= '0;
            sum_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StLoadA: if (accept) begin
                    w1_q[4*load_idx +: 4] <= in_digit;
                    if (cnt_q == 4'd0) begin
                        op_q  <= op_i;
                        sum_q <= '0;
                        neg_q <= 1'b0;
                        err_q <= in_bad;
                    end else begin
                        err_q <= err_q | in_bad;
                    end
                    if (last_digit) begin
                        state_q <= StLoadB;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StLoadB: if (accept) begin
                    w2_q[4*load_idx +: 4] <= in_digit;
                    err_q <= err_q | in_bad;
                    if (last_digit) begin
                        state_q <= StCalc;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StCalc: begin
                    sum_q[4*cnt_q +: 4] <= res_dig;
                    carry_q <= res_carry;
                    if (cnt_q == 4'd0) neg_q <= swap;
                    if (last_digit) begin
                        // Subtract always ends with no borrow since the larger operand is on top.
                        sum_q[W +: 4] <= sub_mode ? 4'd0 : {3'b0, res_carry};
                        state_q <= StDone;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StLoadA;
                    cnt_q   <= '0;
                end
                default: state_q <= StLoadA;
            endcase
        end
    end

    assign w1_o        = w1_q;
    assign w2_o        = w2_q;
    assign sum_o       = sum_q;
    assign neg_o       = neg_q;
    assign digit_err_o = err_q;
    assign done_o      = done_q;
endmodule
